// File: rtl/sub16_pkg.sv
// Shared constants and state encoding for the serial 16-bit subtractor.
//   WIDTH : operand/result width
//   SLICE : bits processed per RUN cycle
//   STEPS : number of RUN cycles per operation
package sub16_pkg;

  localparam int WIDTH = 16;
  localparam int SLICE = 4;
  localparam int STEPS = WIDTH / SLICE;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/sub_slice_4.sv
// Combinational 4-bit borrow-ripple subtractor: d = a - b - bin.
// Ports:
//   a, b : 4-bit minuend / subtrahend
//   bin  : borrow in
//   d    : 4-bit difference
//   bout : borrow out of bit 3
module sub_slice_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);

  // Scalar ripple variable keeps the chain a simple sequential evaluation.
  logic c;

  always_comb begin
    c = bin;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      d[i] = a[i] ^ b[i] ^ c;
      c    = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & c);
    end
    bout = c;
  end

endmodule

// File: rtl/sub_16_serial.sv
// Multi-cycle 16-bit subtractor: diff = inp1 - inp2 - bin, one 4-bit slice
// per clock, LSB slice first, through a single shared slice subtractor.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start, ready      : request / accept handshake (accepted when ready=1)
//   inp1, inp2, bin   : operands and borrow-in, sampled at the accepting edge
//   done              : one-cycle pulse, result valid
//   diff, bout, zero, ovf : registered result and flags
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | ready=1, waiting for start, holding last result
// RUN   | one slice per edge, idx 0..STEPS-1
// DONE  | done=1 for one cycle, then back to IDLE
module sub_16_serial
  import sub16_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  input  logic             bin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam logic [1:0] LAST = 2'(STEPS - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] op_a, op_b;
  logic             borrow;
  logic [1:0]       idx;

  logic [SLICE-1:0] s_a, s_b, s_d;
  logic             s_bout;
  logic [WIDTH-1:0] diff_new;

  assign s_a = op_a[int'(idx)*SLICE +: SLICE];
  assign s_b = op_b[int'(idx)*SLICE +: SLICE];

  sub_slice_4 u_slice (
    .a    (s_a),
    .b    (s_b),
    .bin  (borrow),
    .d    (s_d),
    .bout (s_bout)
  );

  // Full result as it will look after this edge; flags on the last slice
  // must see the freshly written top slice.
  always_comb begin
    diff_new = diff;
    diff_new[int'(idx)*SLICE +: SLICE] = s_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = IDLE;
    ready      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready      = 1'b1;
        state_next = start ? RUN : IDLE;
      end
      RUN:  state_next = (idx == LAST) ? DONE : RUN;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      borrow <= 1'b0;
      idx    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a   <= inp1;
            op_b   <= inp2;
            borrow <= bin;
            idx    <= '0;
          end
        end
        RUN: begin
          diff   <= diff_new;
          borrow <= s_bout;
          idx    <= idx + 2'd1;
          if (idx == LAST) begin
            bout <= s_bout;
            zero <= (diff_new == '0);
            ovf  <= (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                    (diff_new[WIDTH-1] != op_a[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_16_serial.sv
module tb_sub_16_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] inp1 = '0;
  logic [15:0] inp2 = '0;
  logic        bin = 1'b0;
  logic        ready, done, bout, zero, ovf;
  logic [15:0] diff;

  int n_tests = 0;
  int n_fail  = 0;

  sub_16_serial dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .inp1  (inp1),
    .inp2  (inp2),
    .bin   (bin),
    .ready (ready),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .zero  (zero),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op from IDLE and check latency, busy window, result and flags.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic bi, input logic [15:0] e_diff,
                       input logic e_bout, input logic e_zero, input logic e_ovf);
    int k;
    int busy;
    @(negedge clk);
    check({tag, "_ready_before"}, 32'(ready), 32'd1);
    inp1 = a; inp2 = b; bin = bi; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    k = 1;
    busy = 0;
    while (!done && k < 10) begin
      if (!ready) busy++;
      @(negedge clk);
      k++;
    end
    if (!ready) busy++;
    check({tag, "_latency"}, 32'(k), 32'd5);
    check({tag, "_diff"}, 32'(diff), 32'(e_diff));
    check({tag, "_flags"}, {29'd0, bout, zero, ovf}, {29'd0, e_bout, e_zero, e_ovf});
    @(negedge clk);
    check({tag, "_ready_after"}, {30'd0, ready, done}, 32'b10);
    check({tag, "_busy"}, 32'(busy), 32'd5);
  endtask

  initial begin
    int dones;

    #2;
    check("reset_outputs", {10'd0, ready, done, diff, bout, zero, ovf}, {10'd0, 1'b1, 1'b0, 16'h0000, 3'b000});
    @(negedge clk);
    rst = 1'b0;

    do_op("basic", 16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0, 1'b0);
    do_op("wrap",  16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    do_op("ovf_neg", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1);
    do_op("ovf_pos", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1);
    do_op("zero_eq", 16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    do_op("zero_bin", 16'h0010, 16'h000F, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);

    // Busy start: a second request during RUN cycle 2 must be ignored.
    @(negedge clk);
    inp1 = 16'hA000; inp2 = 16'h0001; bin = 1'b0; start = 1'b1;
    @(posedge clk);                  // E0
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    @(negedge clk);                  // after E1: RUN cycle 2
    inp1 = 16'hFFFF; inp2 = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done) begin
        dones++;
        check("busy_diff", 32'(diff), 32'h9FFF);
        check("busy_flags", {29'd0, bout, zero, ovf}, 32'd0);
      end
      @(negedge clk);
    end
    check("busy_done_count", 32'(dones), 32'd1);

    // Reset mid-operation: outputs clear asynchronously, no done follows.
    @(negedge clk);
    inp1 = 16'hFFFF; inp2 = 16'h0001; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_outputs", {10'd0, ready, done, diff, bout, zero, ovf}, {10'd0, 1'b1, 1'b0, 16'h0000, 3'b000});
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    check("rst_mid_no_done", 32'(dones), 32'd0);

    do_op("after_rst", 16'h0003, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sub_16_serial.md
Name: sub_16_serial

Overview:
- Multi-cycle 16-bit subtractor. Counterpart of the 16-bit ripple adder: computes diff = inp1 - inp2 - bin.
- Processes one 4-bit slice per clock through a single 4-bit borrow-ripple slice, LSB slice first.
- Uses a start/ready/done handshake and produces borrow, zero and signed-overflow flags.
- Sits beside the adder in the 16-bit CPU datapath; the ALU uses it for SUB/CMP.

Parameters:
- WIDTH, 16, operand and result width.
- SLICE, 4, bits processed per RUN cycle. STEPS = WIDTH/SLICE = 4. WIDTH must be a multiple of SLICE.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only in a cycle where ready=1.
- inp1  in  16  minuend; sampled at the accepting edge.
- inp2  in  16  subtrahend; sampled at the accepting edge.
- bin  in  1  borrow-in; sampled at the accepting edge.
- ready  out  1  high only in IDLE.
- done  out  1  one-cycle pulse; result valid.
- diff  out  16  result register.
- bout  out  1  borrow out of bit 15; 1 iff inp1 < inp2 + bin (unsigned).
- zero  out  1  diff == 16'h0000.
- ovf  out  1  signed overflow: (a[15] != b[15]) && (diff[15] != a[15]).

Behaviour:
- Reset (async, any state): state=IDLE, ready=1, done=0, diff=0, bout=0, zero=0, ovf=0. Operand registers, slice index and borrow register are cleared. An in-flight operation is abandoned and no done is issued.
- States: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - If start=1 at a rising edge: latch a=inp1, b=inp2, borrow=bin, idx=0; go to RUN.
  - Outputs keep the previous result until that edge.
- RUN:
  - ready=0.
  - Each edge: diff[idx*4 +: 4] <= a[idx*4 +: 4] - b[idx*4 +: 4] - borrow; borrow <= slice borrow-out; idx <= idx+1.
  - At the edge processing idx=3: capture bout (final borrow), zero and ovf, computed from the complete diff including the new top slice. Then go to DONE.
- DONE: done=1 and ready=0 for exactly one cycle, then return to IDLE unconditionally.
- Latency: start accepted at edge E0. Slices are written at E1..E4. done is high in the cycle after E4. ready returns one cycle later.
- Throughput: one operation per 6 cycles.
- During RUN the low slices of diff update progressively. diff, bout, zero and ovf are defined only when done=1 or in IDLE after a completed operation. They hold until the next accepted start's first RUN edge.
- Flags are registered. They change only at the final RUN edge or on reset.
- start while ready=0 (RUN or DONE): ignored. The latched operands are not disturbed and no request is queued.
- start held high continuously: a new operation is accepted at every IDLE cycle, i.e. back-to-back ops every 6 cycles.
- Wrap-around: unsigned modular result, e.g. 0 - 1 = 16'hFFFF with bout=1.
- The idx counter is 2 bits. No other state exists beyond IDLE, RUN and DONE; an illegal state encoding returns to IDLE.

Decomposition:
- Package sub16_pkg:
  - WIDTH and SLICE constants, and derived STEPS.
  - state_t enum {IDLE, RUN, DONE}.
- Sub-module sub_slice_4: purely combinational 4-bit borrow-ripple subtractor.
  - Ports: a[3:0], b[3:0], bin -> d[3:0], bout.
  - Built from 1-bit full subtractor logic: d = a^b^bin; bout = (~a&b) | (~(a^b)&bin).
  - Instantiated once; the top block muxes slices by idx.

Test Plan:
- Basic: 16'h1234 - 16'h0034, bin=0 -> done 5 cycles after the accepting edge; diff=16'h1200, bout=0, zero=0, ovf=0. ready low for exactly 5 cycles.
- Wrap and borrow: 16'h0000 - 16'h0001 -> diff=16'hFFFF, bout=1, zero=0, ovf=0. Check a borrow rippling across all 4 slices.
- Signed overflow: 16'h8000 - 16'h0001 -> diff=16'h7FFF, bout=0, ovf=1. Also 16'h7FFF - 16'hFFFF -> diff=16'h8000, bout=1, ovf=1.
- Zero and borrow-in: 16'h5555 - 16'h5555, bin=0 -> diff=0, zero=1. Then 16'h0010 - 16'h000F, bin=1 -> diff=0, zero=1, bout=0.
- Busy start: accept 16'hA000 - 16'h0001. Pulse start with 16'hFFFF/16'hFFFF during RUN cycle 2 -> ignored; result diff=16'h9FFF, and only one done pulse appears.
- Reset mid-op: assert rst asynchronously during RUN cycle 2 -> all outputs 0 and ready=1 immediately; no done pulse. A subsequent 16'h0003 - 16'h0001 yields diff=16'h0002.
